// File: rtl/bsg_mem_2rw_byte_req_pkg.sv
// Shared constants and types for the two-port byte-masked RAM request controller.
package bsg_mem_2rw_byte_req_pkg;

  localparam int resp_fifo_els_gp = 3;
  // A port may hold at most this many reads between acceptance and consumption.
  localparam int credit_limit_gp  = resp_fifo_els_gp;

  typedef enum logic {
    CTRL_RESET = 1'b0,
    CTRL_RUN   = 1'b1
  } ctrl_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_mem_2rw_byte_req_ctrl_if.sv
// One requester port: client request, buffered response and the matching RAM port pins.
interface bsg_mem_2rw_byte_req_ctrl_if #(
  parameter int width_p = 64,
  parameter int els_p   = 512
);

  localparam int addr_width_lp = bsg_mem_2rw_byte_req_pkg::safe_clog2(els_p);
  localparam int mask_width_lp = width_p >> 3;

  logic                     v;
  logic                     ready;
  logic                     w;
  logic [addr_width_lp-1:0] addr;
  logic [width_p-1:0]       data;
  logic [mask_width_lp-1:0] mask;

  logic [width_p-1:0]       resp_data;
  logic                     resp_v;
  logic                     yumi;

  logic                     mem_v;
  logic                     mem_w;
  logic [addr_width_lp-1:0] mem_addr;
  logic [width_p-1:0]       mem_data;
  logic [mask_width_lp-1:0] mem_w_mask;
  logic [width_p-1:0]       mem_rdata;

  // Client and RAM model side.
  modport master (
    output v, w, addr, data, mask, yumi, mem_rdata,
    input  ready, resp_data, resp_v, mem_v, mem_w, mem_addr, mem_data, mem_w_mask
  );

  // Controller side.
  modport slave (
    input  v, w, addr, data, mask, yumi, mem_rdata,
    output ready, resp_data, resp_v, mem_v, mem_w, mem_addr, mem_data, mem_w_mask
  );

endinterface

// File: rtl/bsg_mem_2rw_byte_resp_buf.sv
// Per-port read response path: in-flight flag, 3-entry response FIFO and credit check.
module bsg_mem_2rw_byte_resp_buf
  import bsg_mem_2rw_byte_req_pkg::*;
#(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               rd_accept,
  input  logic [width_p-1:0] mem_rdata,
  input  logic               yumi,
  output logic               credit_ok,
  output logic               resp_v,
  output logic [width_p-1:0] resp_data
);

  localparam int ptr_w_lp = safe_clog2(resp_fifo_els_gp);
  localparam int cnt_w_lp = $clog2(resp_fifo_els_gp + 1);
  localparam logic [cnt_w_lp:0]   credit_limit_lp = (cnt_w_lp + 1)'(credit_limit_gp);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp     = ptr_w_lp'(resp_fifo_els_gp - 1);

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  logic                inflight_vld_p1;
  logic [width_p-1:0]  fifo_mem [resp_fifo_els_gp];
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic [cnt_w_lp:0]   outstanding;
  logic                push;
  logic                pop;

  assign push        = inflight_vld_p1;
  assign pop         = yumi & resp_v;
  assign resp_v      = (count_r != '0);
  assign resp_data   = fifo_mem[rd_ptr_r];
  assign outstanding = {1'b0, count_r} + {{cnt_w_lp{1'b0}}, inflight_vld_p1};
  // Registered state only, so the consumer's yumi never reaches ready.
  assign credit_ok   = (outstanding < credit_limit_lp);

  // Stage p0 -> p1: RAM samples the address; the read result appears next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inflight_vld_p1 <= 1'b0;
    end else begin
      inflight_vld_p1 <= rd_accept;
    end
  end

  // Stage p1 -> FIFO: capture RAM read data alongside the in-flight flag.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_r] <= mem_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_mem_2rw_byte_req_ctrl.sv
// Two-port byte-masked RAM front end: collision arbitration, RAM pin drive, buffered read responses.
module bsg_mem_2rw_byte_req_ctrl
  import bsg_mem_2rw_byte_req_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 512
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_mem_2rw_byte_req_ctrl_if.slave    a,
  bsg_mem_2rw_byte_req_ctrl_if.slave    b
);

  if ((width_p == 0) || ((width_p % 8) != 0)) begin : g_bad_width
    $error("width_p must be a non-zero multiple of 8");
  end
  if (els_p < 1) begin : g_bad_els
    $error("els_p must be at least 1");
  end

  ctrl_state_e state_r;
  ctrl_state_e state_n;
  logic        en;

  // Requests stay blocked for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= CTRL_RESET;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    en      = 1'b0;
    case (state_r)
      CTRL_RESET: state_n = CTRL_RUN;
      CTRL_RUN:   en      = 1'b1;
      default:    state_n = CTRL_RESET;
    endcase
  end

  logic collision;
  logic a_credit_ok;
  logic b_credit_ok;
  logic a_accept;
  logic b_accept;

  // Two reads of one word are harmless; anything involving a write goes to port A first.
  assign collision = a.v & b.v & (a.addr == b.addr) & (a.w | b.w);

  assign a.ready  = en & a_credit_ok;
  assign b.ready  = en & b_credit_ok & ~collision;
  assign a_accept = a.v & a.ready;
  assign b_accept = b.v & b.ready;

  // Stage p0: accepted requests drive the RAM pins in the same cycle.
  assign a.mem_v      = a_accept;
  assign a.mem_w      = a.w;
  assign a.mem_addr   = a.addr;
  assign a.mem_data   = a.data;
  assign a.mem_w_mask = a.mask;

  assign b.mem_v      = b_accept;
  assign b.mem_w      = b.w;
  assign b.mem_addr   = b.addr;
  assign b.mem_data   = b.data;
  assign b.mem_w_mask = b.mask;

  bsg_mem_2rw_byte_resp_buf #(
    .width_p (width_p)
  ) a_resp (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .rd_accept (a_accept & ~a.w),
    .mem_rdata (a.mem_rdata),
    .yumi      (a.yumi),
    .credit_ok (a_credit_ok),
    .resp_v    (a.resp_v),
    .resp_data (a.resp_data)
  );

  bsg_mem_2rw_byte_resp_buf #(
    .width_p (width_p)
  ) b_resp (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .rd_accept (b_accept & ~b.w),
    .mem_rdata (b.mem_rdata),
    .yumi      (b.yumi),
    .credit_ok (b_credit_ok),
    .resp_v    (b.resp_v),
    .resp_data (b.resp_data)
  );

endmodule

// File: tb/tb_bsg_mem_2rw_byte_req_ctrl.sv
// Directed bench with a RAM model and per-port response scoreboards.
`timescale 1ns/1ps
module tb_bsg_mem_2rw_byte_req_ctrl;

  localparam int width_p = 64;
  localparam int els_p   = 512;
  localparam int aw      = 9;
  localparam int mw      = 8;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bsg_mem_2rw_byte_req_ctrl_if #(.width_p(width_p), .els_p(els_p)) a_if ();
  bsg_mem_2rw_byte_req_ctrl_if #(.width_p(width_p), .els_p(els_p)) b_if ();

  bsg_mem_2rw_byte_req_ctrl #(.width_p(width_p), .els_p(els_p)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .a         (a_if.slave),
    .b         (b_if.slave)
  );

  function automatic logic [63:0] init_word(input int i);
    return {16'hC0DE, 16'(i), 16'hBEEF ^ 16'(i), 16'(i * 7)};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < mw; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // RAM model: synchronous, one-cycle read latency, byte write enables.
  logic [63:0] ram [els_p];
  logic [63:0] a_q, b_q;
  logic        ram_inited = 1'b0;
  always @(posedge clk_i) begin
    if (!ram_inited) begin
      for (int i = 0; i < els_p; i++) ram[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else begin
      if (a_if.mem_v) begin
        if (a_if.mem_w) begin
          for (int k = 0; k < mw; k++)
            if (a_if.mem_w_mask[k]) ram[a_if.mem_addr][8*k +: 8] <= a_if.mem_data[8*k +: 8];
        end else a_q <= ram[a_if.mem_addr];
      end
      if (b_if.mem_v) begin
        if (b_if.mem_w) begin
          for (int k = 0; k < mw; k++)
            if (b_if.mem_w_mask[k]) ram[b_if.mem_addr][8*k +: 8] <= b_if.mem_data[8*k +: 8];
        end else b_q <= ram[b_if.mem_addr];
      end
    end
  end
  assign a_if.mem_rdata = a_q;
  assign b_if.mem_rdata = b_q;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sh [els_p];
  logic [63:0] qa [$];
  logic [63:0] qb [$];
  int n_acc_a = 0, n_acc_b = 0;
  bit auto_a = 1'b1, auto_b = 1'b1, force_yumi_a = 1'b0;
  logic s_a_ready, s_b_ready, s_a_vo, s_b_vo, s_mem_a_v, s_mem_a_w, s_mem_b_v;
  logic [63:0] s_a_data, s_b_data;
  logic [aw-1:0] s_mem_a_addr;
  logic [mw-1:0] s_mem_a_mask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input bit v, input bit w, input int addr, input logic [63:0] d,
                         input logic [7:0] m);
    a_if.v = v; a_if.w = w; a_if.addr = aw'(addr); a_if.data = d; a_if.mask = m;
  endtask

  task automatic drive_b(input bit v, input bit w, input int addr, input logic [63:0] d,
                         input logic [7:0] m);
    b_if.v = v; b_if.w = w; b_if.addr = aw'(addr); b_if.data = d; b_if.mask = m;
  endtask

  task automatic sample();
    logic [63:0] exp;
    bit acc_a, acc_b;
    s_a_ready = a_if.ready;   s_b_ready = b_if.ready;
    s_a_vo = a_if.resp_v;     s_b_vo = b_if.resp_v;
    s_a_data = a_if.resp_data; s_b_data = b_if.resp_data;
    s_mem_a_v = a_if.mem_v;   s_mem_a_w = a_if.mem_w;   s_mem_b_v = b_if.mem_v;
    s_mem_a_addr = a_if.mem_addr; s_mem_a_mask = a_if.mem_w_mask;
    if (a_if.resp_v && a_if.yumi) begin
      check("a_sb_has_entry", 64'(qa.size() > 0), 64'd1);
      if (qa.size() > 0) begin exp = qa.pop_front(); check("a_resp_data", a_if.resp_data, exp); end
    end
    if (b_if.resp_v && b_if.yumi) begin
      check("b_sb_has_entry", 64'(qb.size() > 0), 64'd1);
      if (qb.size() > 0) begin exp = qb.pop_front(); check("b_resp_data", b_if.resp_data, exp); end
    end
    acc_a = a_if.v && a_if.ready;
    acc_b = b_if.v && b_if.ready;
    if (acc_a && !a_if.w) qa.push_back(sh[a_if.addr]);
    if (acc_b && !b_if.w) qb.push_back(sh[b_if.addr]);
    if (acc_a && a_if.w) sh[a_if.addr] = merge(sh[a_if.addr], a_if.data, a_if.mask);
    if (acc_b && b_if.w) sh[b_if.addr] = merge(sh[b_if.addr], b_if.data, b_if.mask);
    if (acc_a) n_acc_a++;
    if (acc_b) n_acc_b++;
  endtask

  task automatic cycle();
    #2;
    a_if.yumi = auto_a ? a_if.resp_v : force_yumi_a;
    b_if.yumi = auto_b ? b_if.resp_v : 1'b0;
    #2;
    sample();
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    drive_a(0, 0, 0, '0, '0);
    drive_b(0, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0a, n0b, n_vo;
    for (int i = 0; i < els_p; i++) sh[i] = init_word(i);
    drive_a(0, 0, 0, '0, '0); drive_b(0, 0, 0, '0, '0);
    a_if.yumi = 1'b0; b_if.yumi = 1'b0;
    @(posedge clk_i); #1;

    // Reset held with a request pending.
    drive_a(1, 0, 0, '0, '0);
    cycle(); cycle();
    check("rst_a_ready", 64'(s_a_ready), 64'd0);
    check("rst_mem_a_v", 64'(s_mem_a_v), 64'd0);
    check("rst_a_v_o",   64'(s_a_vo),    64'd0);
    drive_a(0, 0, 0, '0, '0);
    reset_n_i = 1'b1;
    cycle();
    cycle();
    check("rel_a_ready", 64'(s_a_ready), 64'd1);
    check("rel_b_ready", 64'(s_b_ready), 64'd1);

    // Full write then read-back on port A.
    drive_a(1, 1, 5, 64'h1122334455667788, 8'hFF);
    cycle();
    check("wr_a_ready",    64'(s_a_ready),    64'd1);
    check("wr_mem_a_w",    64'(s_mem_a_w),    64'd1);
    check("wr_mem_a_addr", 64'(s_mem_a_addr), 64'd5);
    check("wr_mem_a_mask", 64'(s_mem_a_mask), 64'hFF);
    drive_a(1, 0, 5, '0, '0);
    cycle();
    check("rd_a_ready", 64'(s_a_ready), 64'd1);
    drive_a(0, 0, 0, '0, '0);
    cycle();
    check("rd_a_v_early", 64'(s_a_vo), 64'd0);
    cycle();
    check("rd_a_v",    64'(s_a_vo), 64'd1);
    check("rd_a_data", s_a_data,    64'h1122334455667788);

    // Byte-masked write from B, read back on A.
    drive_b(1, 1, 5, {8{8'hAA}}, 8'h0F);
    cycle();
    check("bw_b_ready", 64'(s_b_ready), 64'd1);
    drive_b(0, 0, 0, '0, '0);
    drive_a(1, 0, 5, '0, '0);
    cycle();
    drive_a(0, 0, 0, '0, '0);
    cycle(); cycle();
    check("bm_a_v",    64'(s_a_vo), 64'd1);
    check("bm_a_data", s_a_data,    64'h11223344AAAAAAAA);

    // Collision: A writes while B reads the same word.
    drive_a(1, 1, 9, 64'hDEADBEEF09090909, 8'hFF);
    drive_b(1, 0, 9, '0, '0);
    cycle();
    check("col_a_ready", 64'(s_a_ready), 64'd1);
    check("col_b_ready", 64'(s_b_ready), 64'd0);
    check("col_mem_b_v", 64'(s_mem_b_v), 64'd0);
    drive_a(0, 0, 0, '0, '0);
    cycle();
    check("col_b_retry", 64'(s_b_ready), 64'd1);
    drive_b(0, 0, 0, '0, '0);
    cycle(); cycle();
    check("col_b_v",    64'(s_b_vo), 64'd1);
    check("col_b_data", s_b_data,    64'hDEADBEEF09090909);
    drive_a(1, 0, 9, '0, '0);
    drive_b(1, 0, 9, '0, '0);
    cycle();
    check("rr_a_ready", 64'(s_a_ready), 64'd1);
    check("rr_b_ready", 64'(s_b_ready), 64'd1);
    drive_b(1, 1, 9, 64'h5555666677778888, 8'hF0);
    cycle();
    check("rw_b_ready", 64'(s_b_ready), 64'd0);
    drive_a(0, 0, 0, '0, '0);
    cycle();
    check("rw_b_retry", 64'(s_b_ready), 64'd1);
    drive_b(0, 0, 0, '0, '0);
    drive_a(1, 0, 9, '0, '0);
    cycle();
    idle(4);

    // Backpressure on port A.
    auto_a = 1'b0; force_yumi_a = 1'b0;
    n0a = n_acc_a;
    for (int i = 0; i < 5; i++) begin
      drive_a(1, 0, 20 + (n_acc_a - n0a), '0, '0);
      cycle();
    end
    check("bp_accepts",   64'(n_acc_a - n0a), 64'd3);
    check("bp_ready_low", 64'(s_a_ready),     64'd0);
    drive_a(1, 0, 23, '0, '0);
    force_yumi_a = 1'b1;
    cycle();
    check("bp_ready_yumi_cycle", 64'(s_a_ready), 64'd0);
    force_yumi_a = 1'b0;
    cycle();
    check("bp_ready_after_yumi", 64'(s_a_ready), 64'd1);
    auto_a = 1'b1;
    idle(6);
    check("bp_drained", 64'(qa.size()), 64'd0);

    // Reset while a read is in flight.
    drive_a(1, 0, 30, '0, '0);
    cycle();
    check("mf_accept", 64'(s_a_ready), 64'd1);
    drive_a(0, 0, 0, '0, '0);
    reset_n_i = 1'b0;
    qa.delete();
    cycle(); cycle();
    reset_n_i = 1'b1;
    n_vo = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_a_vo) n_vo++;
    end
    check("mf_no_resp", 64'(n_vo),      64'd0);
    check("mf_ready",   64'(s_a_ready), 64'd1);

    // Sustained throughput on both ports.
    n0a = n_acc_a; n0b = n_acc_b;
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 0, 40 + i, '0, '0);
      drive_b(1, 0, 60 + i, '0, '0);
      cycle();
    end
    check("tp_a_accepts", 64'(n_acc_a - n0a), 64'd8);
    check("tp_b_accepts", 64'(n_acc_b - n0b), 64'd8);
    idle(6);
    check("sb_a_empty", 64'(qa.size()), 64'd0);
    check("sb_b_empty", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_mem_2rw_byte_req_ctrl.md
# bsg_mem_2rw_byte_req_ctrl

Requester-side front end for a two-port, byte-masked synchronous RAM: one clock, a one-cycle read latency, and an 8-bit byte-lane write mask. The block accepts two independent valid/ready request streams, A and B. It resolves same-address collisions between the ports before they reach the array. Read data is buffered per port behind valid/yumi so that each consumer can apply backpressure. It sits between cache/DMA clients and the RAM, and drives the RAM's a_*/b_* port pins directly.

## Interface
Parameters:
- width_p, 64, data width in bits; must be a non-zero multiple of 8
- els_p, 512, number of RAM words
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived)
- mask_width_lp, width_p>>3, byte-mask width (derived)

Ports (clock is clk_i; reset is reset_n_i, **asynchronous, active-low**):
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- a_v_i  in  1  port A request valid
- a_ready_o  out  1  port A request accepted when a_v_i & a_ready_o
- a_w_i  in  1  1 = write, 0 = read
- a_addr_i  in  addr_width_lp  word address
- a_data_i  in  width_p  write data
- a_mask_i  in  mask_width_lp  byte write enables; ignored on reads
- a_data_o  out  width_p  read response data
- a_v_o  out  1  read response valid
- a_yumi_i  in  1  consumer takes the head response; legal only when a_v_o is 1
- mem_a_v_o, mem_a_w_o, mem_a_addr_o, mem_a_data_o, mem_a_w_mask_o  out  1/1/addr_width_lp/width_p/mask_width_lp  RAM port A drive
- mem_a_data_i  in  width_p  RAM port A read data, valid the cycle after the access
- b_* and mem_b_*: same set as port A, with prefix b_ and mem_b_

## Operation
- **Accept:** a request is accepted when v_i & ready_o. The accepted request is forwarded combinationally to the RAM in the same cycle.
  - mem_v_o = accept; mem_w_o = w_i; mem_addr_o = addr_i; mem_data_o = data_i; mem_w_mask_o = mask_i.
  - A write with an all-zero mask is accepted and forwarded unchanged.
- **Credit per port:** outstanding = fifo_count + inflight.
  - inflight is a 1-bit register: 1 when a read was accepted in the previous cycle.
  - ready_o requires outstanding < 3. The check uses registered state only; yumi_i has no combinational path to ready_o.
  - The check applies to reads and writes alike.
- **Response FIFO per port:** 3 entries.
  - When inflight=1, mem_data_i is written into the FIFO at the clock edge ending that cycle.
  - v_o = fifo_count != 0; data_o = head entry; yumi_i pops the head.
  - A push and a pop in the same cycle leave the count unchanged.
- **Writes produce no response.**
- **Collision:** a collision exists when a_v_i & b_v_i & (a_addr_i == b_addr_i) & (a_w_i | b_w_i).
  - On a collision, port A wins and b_ready_o = 0 for that cycle.
  - Two reads of the same address do not collide.
  - b_ready_o therefore depends combinationally on the port A inputs. a_ready_o never depends on port B.
- **Ordering:** each port's responses return in the order its reads were accepted.
- **Reset:** reset_n_i low asynchronously clears fifo_count, FIFO pointers and inflight.
  - While reset is asserted: ready_o=0, v_o=0, mem_v_o=0.
  - A read in flight when reset asserts is discarded. RAM data arriving in the first cycle after deassertion is not captured.

## Timing
- **Read latency:** accepted in cycle t; v_o=1 in cycle t+2 at the earliest.
- **Throughput:** one read per port per cycle is sustained when yumi_i is asserted on every cycle that v_o=1.
- **Backpressure:** with yumi_i held low, a port accepts exactly 3 reads. ready_o returns to 1 in the cycle after the first yumi_i.
- **Write visibility:** a write accepted in cycle t is visible to a read of the same address, on either port, accepted in cycle t+1 or later.
- **Collision stall:** a port B request stalled by a collision in cycle t is accepted in cycle t+1 if no collision exists then. B's stall lasts as long as A keeps presenting a colliding request (no fairness guarantee).

## Structure
- **Shared package bsg_mem_2rw_byte_req_pkg:** resp_fifo_els_gp = 3 and the credit-limit constant.
- **Sub-module bsg_mem_2rw_byte_resp_buf:** holds the inflight flag, the 3-entry FIFO and the credit count; instantiated once per port.
- **Top level:** the collision comparator and the RAM pin assignments.

## Test plan
- **Reset:** hold reset_n_i low with a_v_i=1 -> a_ready_o=0, mem_a_v_o=0, a_v_o=0. Release -> a_ready_o=1 on the next cycle.
- **Basic write/read:** A writes 0x1122334455667788 to addr 5 with mask 0xFF at t. A reads addr 5 at t+1 -> a_v_o=1 at t+3 with that data.
- **Byte-masked write:** B writes 0xAAAA…AA to addr 5 with mask 0x0F. A then reads addr 5 -> 0x11223344AAAAAAAA.
- **Collision:** A writes addr 9 while B reads addr 9 in the same cycle -> b_ready_o=0, B accepted next cycle, B returns A's data. A and B both read addr 9 -> both accepted in the same cycle.
- **Backpressure:** issue 5 back-to-back A reads with a_yumi_i=0 -> exactly 3 accepted. Pulse a_yumi_i -> the next read is accepted one cycle later, and responses arrive in issue order.
- **Reset mid-flight:** assert reset_n_i the cycle after a read is accepted -> no response appears after reset release, and the FIFO count is 0.
